// File: rtl/immediate_mux.sv
// Immediate-operand selector: picks one of the pre-extended J/U/B/S/I immediates
// by imm_type and registers it, together with a flag for reserved select codes.
module immediate_mux #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      imm_type,
  input  logic [XLEN-1:0] imm_J,
  input  logic [XLEN-1:0] imm_U,
  input  logic [XLEN-1:0] imm_B,
  input  logic [XLEN-1:0] imm_S,
  input  logic [XLEN-1:0] imm_I,
  output logic [XLEN-1:0] imm,
  output logic            imm_illegal
);

  typedef enum logic [2:0] {
    IMM_J = 3'b000,
    IMM_U = 3'b001,
    IMM_B = 3'b010,
    IMM_S = 3'b011,
    IMM_I = 3'b100
  } imm_fmt_e;

  logic [XLEN-1:0] imm_d, imm_q;
  logic            illegal_d, illegal_q;

  // Reserved codes and any X/Z on imm_type fall through to the default arm.
  always_comb begin
    imm_d     = '0;
    illegal_d = 1'b0;
    case (imm_type)
      IMM_J:   imm_d = imm_J;
      IMM_U:   imm_d = imm_U;
      IMM_B:   imm_d = imm_B;
      IMM_S:   imm_d = imm_S;
      IMM_I:   imm_d = imm_I;
      default: begin
        imm_d     = '0;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign imm         = imm_q;
  assign imm_illegal = illegal_q;

endmodule

// File: tb/tb_immediate_mux.sv
// Directed bench for immediate_mux: expected outputs queued when inputs are
// driven, popped and compared one rising edge later.
module tb_immediate_mux;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [2:0]      imm_type;
  logic [XLEN-1:0] imm_J, imm_U, imm_B, imm_S, imm_I;
  logic [XLEN-1:0] imm;
  logic            imm_illegal;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;

  logic [XLEN:0] sb[$];

  immediate_mux #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .imm_type    (imm_type),
    .imm_J       (imm_J),
    .imm_U       (imm_U),
    .imm_B       (imm_B),
    .imm_S       (imm_S),
    .imm_I       (imm_I),
    .imm         (imm),
    .imm_illegal (imm_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_imm(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: imm got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ill(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: imm_illegal got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue the expectation,
  // then compare just after the following rising edge.
  task automatic step(input string tag, input logic [2:0] t,
                      input logic [XLEN-1:0] j, input logic [XLEN-1:0] u,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] s,
                      input logic [XLEN-1:0] i);
    logic [XLEN-1:0] ins[5];
    logic [XLEN:0]   e;
    @(negedge clk);
    imm_type = t; imm_J = j; imm_U = u; imm_B = b; imm_S = s; imm_I = i;
    ins[0] = j; ins[1] = u; ins[2] = b; ins[3] = s; ins[4] = i;
    if (t < 3'd5) e = {1'b0, ins[t]};
    else          e = {1'b1, {XLEN{1'b0}}};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s: scoreboard got empty required entry", tag);
    end else begin
      e = sb.pop_front();
      check_imm(tag, imm, e[XLEN-1:0]);
      check_ill(tag, imm_illegal, e[XLEN]);
    end
  endtask

  logic [XLEN-1:0] vals[5];
  logic [XLEN-1:0] fill[5];
  logic [XLEN-1:0] in_v[5];

  initial begin
    total = 0; passed = 0; failed = 0;
    vals[0] = 32'd10; vals[1] = 32'd3; vals[2] = 32'hFFFF_FFFC;
    vals[3] = 32'd4;  vals[4] = 32'hFFFF_FFF0;
    fill[0] = 32'hDEAD_BEEF; fill[1] = 32'hCAFE_F00D; fill[2] = 32'h1234_5678;
    fill[3] = 32'hA5A5_5A5A; fill[4] = 32'h0BAD_C0DE;

    rst = 1'b0;
    imm_type = 3'b000;
    imm_J = 32'd10; imm_U = '0; imm_B = '0; imm_S = '0; imm_I = '0;

    // Load a value first so the asynchronous clear is observable mid-cycle.
    step("preload", 3'b000, 32'd10, '0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    check_imm("rst_async", imm, '0);
    check_ill("rst_async", imm_illegal, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_imm("rst_hold", imm, '0);
      check_ill("rst_hold", imm_illegal, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    step("rst_release", 3'b000, 32'd10, '0, '0, '0, '0);

    // Format sweeps; unselected inputs carry distinct junk values.
    for (int f = 0; f < 5; f++) begin
      for (int v = 0; v < 5; v++) begin
        for (int h = 0; h < 3; h++) begin
          for (int n = 0; n < 5; n++) in_v[n] = fill[n];
          in_v[f] = vals[v];
          step($sformatf("sweep_f%0d_v%0d", f, v), 3'(f),
               in_v[0], in_v[1], in_v[2], in_v[3], in_v[4]);
          if (f == 4 && v == 2 && h == 1) begin
            #1 rst = 1'b1;
            #1;
            check_imm("mid_rst", imm, '0);
            check_ill("mid_rst", imm_illegal, 1'b0);
            #1 rst = 1'b0;
          end
        end
      end
    end

    // Simultaneous type and data switch.
    step("switch_pre", 3'b000, 32'hFFFF_FFF0, fill[1], fill[2], fill[3], fill[4]);
    step("switch", 3'b001, 32'hFFFF_FFF0, 32'd10, fill[2], fill[3], fill[4]);
    step("switch_hold", 3'b001, 32'hFFFF_FFF0, 32'd10, fill[2], fill[3], fill[4]);

    // Reserved codes, then recovery.
    step("rsv_101", 3'b101, fill[0], fill[1], fill[2], fill[3], fill[4]);
    step("rsv_110", 3'b110, fill[0], fill[1], fill[2], fill[3], fill[4]);
    step("rsv_111", 3'b111, fill[0], fill[1], fill[2], fill[3], fill[4]);
    step("rsv_exit", 3'b100, fill[0], fill[1], fill[2], fill[3], 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
